// File: rtl/ast_packet_source_pkg.sv
// Shared types, sizing constants and helpers for the Avalon-ST packet source.
package ast_packet_source_pkg;

  localparam int unsigned AST_DWIDTH    = 64;
  localparam int unsigned BITS_PER_SYMB = 8;
  localparam int unsigned CHANNEL_WIDTH = 1;
  localparam int unsigned LEN_WIDTH     = 16;
  localparam int unsigned MAX_PKT_LEN   = 1514;
  localparam int unsigned BYTES         = AST_DWIDTH / BITS_PER_SYMB;
  localparam int unsigned EMPTY_W       = (BYTES > 1) ? $clog2(BYTES) : 1;

  typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_t;
  typedef enum logic {INC = 1'b0, CONST = 1'b1} mode_t;

  function automatic int unsigned bytes_per_word(input int unsigned dwidth,
                                                 input int unsigned bits_per_symb);
    return dwidth / bits_per_symb;
  endfunction

  function automatic int unsigned words_for_len(input int unsigned len,
                                                input int unsigned bytes);
    return (len + bytes - 1) / bytes;
  endfunction

endpackage

// File: rtl/ast_packet_source_if.sv
// Avalon-ST streaming bus with source and sink views (readyLatency 0).
interface avalon_st_if #(
  parameter int unsigned DATA_W    = 64,
  parameter int unsigned EMPTY_W   = 3,
  parameter int unsigned CHANNEL_W = 1
);
  logic [DATA_W-1:0]    data;
  logic                 valid;
  logic                 ready;
  logic                 startofpacket;
  logic                 endofpacket;
  logic [EMPTY_W-1:0]   empty;
  logic [CHANNEL_W-1:0] channel;

  modport src (output data, valid, startofpacket, endofpacket, empty, channel,
               input  ready);
  modport snk (input  data, valid, startofpacket, endofpacket, empty, channel,
               output ready);
endinterface

// File: rtl/ast_packet_source.sv
// Avalon-ST packet generator: takes one length/pattern command at a time and
// streams a framed packet of incrementing or constant bytes.
module ast_packet_source
  import ast_packet_source_pkg::*;
#(
  parameter int unsigned AST_DWIDTH    = 64,
  parameter int unsigned BITS_PER_SYMB = 8,
  parameter int unsigned CHANNEL_WIDTH = 1,
  parameter int unsigned LEN_WIDTH     = 16,
  parameter int unsigned MAX_PKT_LEN   = 1514
) (
  input  logic                     clk_i,
  input  logic                     arst_n_i,
  input  logic                     cmd_valid_i,
  output logic                     cmd_ready_o,
  input  logic [LEN_WIDTH-1:0]     cmd_len_i,
  input  logic [CHANNEL_WIDTH-1:0] cmd_channel_i,
  input  logic                     cmd_mode_i,
  input  logic [7:0]               cmd_seed_i,
  avalon_st_if.src                 src_if,
  output logic                     busy_o,
  output logic                     cmd_err_o,
  output logic [15:0]              pkt_cnt_o
);

  localparam int unsigned NBYTES   = bytes_per_word(AST_DWIDTH, BITS_PER_SYMB);
  localparam int unsigned EMPTY_WL = (NBYTES > 1) ? $clog2(NBYTES) : 1;

  state_t                   state_q, state_d;
  mode_t                    mode_q, mode_d;
  logic [LEN_WIDTH-1:0]     len_q, len_d;
  logic [LEN_WIDTH-1:0]     words_q, words_d;
  logic [LEN_WIDTH-1:0]     wcnt_q, wcnt_d;
  logic [7:0]               seed_q, seed_d;
  logic [7:0]               base_q, base_d;
  logic [CHANNEL_WIDTH-1:0] chan_q, chan_d;
  logic                     valid_q, valid_d;
  logic                     sop_q, sop_d;
  logic                     eop_q, eop_d;
  logic [AST_DWIDTH-1:0]    data_q, data_d;
  logic [EMPTY_WL-1:0]      empty_q, empty_d;
  logic                     err_q, err_d;
  logic [15:0]              pkt_cnt_q, pkt_cnt_d;

  // Beat builder inputs: the fresh command while idle, the next word while sending
  logic                     sel_cmd;
  logic                     cmd_legal;
  logic [LEN_WIDTH-1:0]     b_len, b_words, b_w;
  logic [7:0]               b_base, b_seed;
  mode_t                    b_mode;
  logic [AST_DWIDTH-1:0]    b_data;
  logic                     b_sop, b_eop;
  logic [EMPTY_WL-1:0]      b_empty;

  assign sel_cmd   = (state_q == IDLE);
  assign cmd_legal = (cmd_len_i != '0) && (32'(cmd_len_i) <= MAX_PKT_LEN);
  assign b_len     = sel_cmd ? cmd_len_i : len_q;
  assign b_words   = sel_cmd ? LEN_WIDTH'(words_for_len(32'(cmd_len_i), NBYTES)) : words_q;
  assign b_w       = sel_cmd ? '0 : LEN_WIDTH'(wcnt_q + LEN_WIDTH'(1));
  assign b_base    = sel_cmd ? cmd_seed_i : 8'(base_q + 8'(NBYTES));
  assign b_seed    = sel_cmd ? cmd_seed_i : seed_q;
  assign b_mode    = sel_cmd ? mode_t'(cmd_mode_i) : mode_q;

  // Lane 0 is the most significant symbol; lanes past the packet end read zero
  always_comb begin
    b_data = '0;
    for (int unsigned lane = 0; lane < NBYTES; lane++) begin
      if ((32'(b_w) * NBYTES + lane) < 32'(b_len)) begin
        b_data[AST_DWIDTH-1-lane*BITS_PER_SYMB -: BITS_PER_SYMB] =
          BITS_PER_SYMB'((b_mode == CONST) ? b_seed : 8'(b_base + 8'(lane)));
      end
    end
    b_sop   = (b_w == '0);
    b_eop   = (b_w == LEN_WIDTH'(b_words - LEN_WIDTH'(1)));
    b_empty = b_eop ? EMPTY_WL'(32'(b_words) * NBYTES - 32'(b_len)) : '0;
  end

  // Next-state and output-register logic
  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    len_d     = len_q;
    words_d   = words_q;
    wcnt_d    = wcnt_q;
    seed_d    = seed_q;
    base_d    = base_q;
    chan_d    = chan_q;
    valid_d   = valid_q;
    sop_d     = sop_q;
    eop_d     = eop_q;
    data_d    = data_q;
    empty_d   = empty_q;
    err_d     = 1'b0;
    pkt_cnt_d = pkt_cnt_q;

    unique case (state_q)
      IDLE: begin
        if (cmd_valid_i) begin
          if (cmd_legal) begin
            state_d = SEND;
            mode_d  = b_mode;
            len_d   = cmd_len_i;
            words_d = b_words;
            wcnt_d  = '0;
            seed_d  = cmd_seed_i;
            base_d  = cmd_seed_i;
            chan_d  = cmd_channel_i;
            valid_d = 1'b1;
            sop_d   = b_sop;
            eop_d   = b_eop;
            data_d  = b_data;
            empty_d = b_empty;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      SEND: begin
        if (src_if.ready) begin
          if (eop_q) begin
            state_d   = IDLE;
            valid_d   = 1'b0;
            sop_d     = 1'b0;
            eop_d     = 1'b0;
            data_d    = '0;
            empty_d   = '0;
            chan_d    = '0;
            pkt_cnt_d = 16'(pkt_cnt_q + 16'd1);
          end else begin
            wcnt_d  = b_w;
            base_d  = b_base;
            sop_d   = b_sop;
            eop_d   = b_eop;
            data_d  = b_data;
            empty_d = b_empty;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      state_q   <= IDLE;
      mode_q    <= INC;
      len_q     <= '0;
      words_q   <= '0;
      wcnt_q    <= '0;
      seed_q    <= '0;
      base_q    <= '0;
      chan_q    <= '0;
      valid_q   <= 1'b0;
      sop_q     <= 1'b0;
      eop_q     <= 1'b0;
      data_q    <= '0;
      empty_q   <= '0;
      err_q     <= 1'b0;
      pkt_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      mode_q    <= mode_d;
      len_q     <= len_d;
      words_q   <= words_d;
      wcnt_q    <= wcnt_d;
      seed_q    <= seed_d;
      base_q    <= base_d;
      chan_q    <= chan_d;
      valid_q   <= valid_d;
      sop_q     <= sop_d;
      eop_q     <= eop_d;
      data_q    <= data_d;
      empty_q   <= empty_d;
      err_q     <= err_d;
      pkt_cnt_q <= pkt_cnt_d;
    end
  end

  assign src_if.data          = data_q;
  assign src_if.valid         = valid_q;
  assign src_if.startofpacket = sop_q;
  assign src_if.endofpacket   = eop_q;
  assign src_if.empty         = empty_q;
  assign src_if.channel       = chan_q;
  assign cmd_ready_o          = (state_q == IDLE);
  assign busy_o               = (state_q == SEND);
  assign cmd_err_o            = err_q;
  assign pkt_cnt_o            = pkt_cnt_q;

endmodule
